// File: rtl/modexp_ladder_sequencer.sv
// Montgomery-ladder sequencer for RSA modular exponentiation.
// Schedules two external Montgomery multipliers (SQ squarer, MUL multiplier)
// that run in parallel on each exponent bit; the 1024-bit datapath (R0, R1,
// operand muxes) lives outside this block.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   start                 - one-cycle request, accepted only while idle
//   exponent, exp_len     - exponent and number of bits to process (clamped to EXP_W)
//   busy, done            - busy outside idle; one-cycle completion pulse (result in R0)
//   sq_start, mul_start   - start pulses to the SQ / MUL units
//   sq_done, mul_done     - completion pulses from the SQ / MUL units
//   sq_sel                - SQ operand: 0=R0, 1=R1
//   mul_sel               - MUL operands: 0=(x,R2_N), 1=(R0,R1), 2=(R0,1)
//   r0_load_rn            - load R0 with R_N
//   r0_we, r0_src         - R0 write enable / source (0=MUL, 1=SQ)
//   r1_we, r1_src         - R1 write enable / source (0=MUL, 1=SQ)
module modexp_ladder_sequencer #(
    parameter int EXP_W = 32,
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [EXP_W-1:0] exponent,
    input  logic [LEN_W-1:0] exp_len,
    output logic             busy,
    output logic             done,
    output logic             sq_start,
    output logic             mul_start,
    input  logic             sq_done,
    input  logic             mul_done,
    output logic             sq_sel,
    output logic [1:0]       mul_sel,
    output logic             r0_load_rn,
    output logic             r0_we,
    output logic             r0_src,
    output logic             r1_we,
    output logic             r1_src
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [LEN_W-1:0] EXP_W_L = LEN_W'(EXP_W);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_S,
        ST_INIT_W,
        ST_STEP_S,
        ST_STEP_W,
        ST_STEP_WB,
        ST_FIN_S,
        ST_FIN_W,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [EXP_W-1:0] exp_q;
    logic             len_zero;
    logic [IDX_W-1:0] idx;
    logic             cur_bit;
    logic             sq_flag;
    logic             mul_flag;
    logic [LEN_W-1:0] len_c;

    assign len_c = (exp_len > EXP_W_L) ? EXP_W_L : exp_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q    <= '0;
            len_zero <= 1'b0;
            idx      <= '0;
            cur_bit  <= 1'b0;
            sq_flag  <= 1'b0;
            mul_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        exp_q    <= exponent;
                        len_zero <= (len_c == '0);
                        // Wraps when len is zero; idx is never used on that path.
                        idx      <= IDX_W'(len_c - LEN_W'(1));
                    end
                end
                ST_STEP_S: begin
                    cur_bit  <= exp_q[idx];
                    sq_flag  <= 1'b0;
                    mul_flag <= 1'b0;
                end
                ST_STEP_W: begin
                    // Remember whichever unit finished first so arrival order is free.
                    if (sq_done)  sq_flag  <= 1'b1;
                    if (mul_done) mul_flag <= 1'b1;
                end
                ST_STEP_WB: begin
                    if (idx != '0) idx <= idx - IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n    = state;
        busy       = (state != ST_IDLE);
        done       = 1'b0;
        sq_start   = 1'b0;
        mul_start  = 1'b0;
        sq_sel     = 1'b0;
        mul_sel    = 2'd0;
        r0_load_rn = 1'b0;
        r0_we      = 1'b0;
        r0_src     = 1'b0;
        r1_we      = 1'b0;
        r1_src     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_n = ST_INIT_S;
            end
            ST_INIT_S: begin
                mul_start  = 1'b1;
                r0_load_rn = 1'b1;
                state_n    = ST_INIT_W;
            end
            ST_INIT_W: begin
                if (mul_done) begin
                    r1_we   = 1'b1;
                    state_n = len_zero ? ST_FIN_S : ST_STEP_S;
                end
            end
            ST_STEP_S: begin
                sq_start  = 1'b1;
                mul_start = 1'b1;
                mul_sel   = 2'd1;
                sq_sel    = exp_q[idx];
                state_n   = ST_STEP_W;
            end
            ST_STEP_W: begin
                mul_sel = 2'd1;
                sq_sel  = cur_bit;
                if ((sq_flag | sq_done) & (mul_flag | mul_done)) state_n = ST_STEP_WB;
            end
            ST_STEP_WB: begin
                mul_sel = 2'd1;
                sq_sel  = cur_bit;
                r0_we   = 1'b1;
                r1_we   = 1'b1;
                r0_src  = ~cur_bit;
                r1_src  = cur_bit;
                state_n = (idx == '0) ? ST_FIN_S : ST_STEP_S;
            end
            ST_FIN_S: begin
                mul_start = 1'b1;
                mul_sel   = 2'd2;
                state_n   = ST_FIN_W;
            end
            ST_FIN_W: begin
                mul_sel = 2'd2;
                if (mul_done) begin
                    r0_we   = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_modexp_ladder_sequencer.sv
// Self-checking bench for modexp_ladder_sequencer.
// Behavioural SQ/MUL units answer each start pulse with a done pulse after a
// programmable latency; expected output events (with their cycle offset from
// the accept edge) are queued when an operation is launched and popped by a
// monitor whenever the sequencer emits a pulse or write enable.
module tb_modexp_ladder_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] exponent = '0;
    logic [5:0]  exp_len = '0;
    logic        busy, done, sq_start, mul_start, sq_sel;
    logic [1:0]  mul_sel;
    logic        r0_load_rn, r0_we, r0_src, r1_we, r1_src;
    logic        sq_done, mul_done;
    logic        sq_done_m = 1'b0, mul_done_m = 1'b0, mul_spur = 1'b0;

    assign sq_done  = sq_done_m;
    assign mul_done = mul_done_m | mul_spur;

    modexp_ladder_sequencer #(.EXP_W(32), .LEN_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .exponent(exponent), .exp_len(exp_len),
        .busy(busy), .done(done), .sq_start(sq_start), .mul_start(mul_start),
        .sq_done(sq_done), .mul_done(mul_done), .sq_sel(sq_sel), .mul_sel(mul_sel),
        .r0_load_rn(r0_load_rn), .r0_we(r0_we), .r0_src(r0_src), .r1_we(r1_we), .r1_src(r1_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] code;
        int          stamp;
    } ev_t;

    ev_t sb_q[$];
    int  sq_lq[$];
    int  mul_lq[$];
    int  dflt_lat = 3;
    int  sq_pos = 0, mul_pos = 0;
    int  sq_cnt = 0, mul_cnt = 0;
    int  cyc = 0, acc = 0;
    int  n_sq = 0, n_mul = 0;
    bit  op_done = 1'b0;
    bit  inject = 1'b0;
    int  n_checks = 0, n_fail = 0;
    int  lat_s, lat_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] enc(input bit dn, input bit ss, input bit ms, input bit ssel,
                                        input bit [1:0] msel, input bit ld, input bit w0,
                                        input bit s0, input bit w1, input bit s1);
        return {dn, ss, ms, ssel, msel, ld, w0, s0, w1, s1};
    endfunction

    function automatic int slat(input int i);
        return (i < sq_lq.size()) ? sq_lq[i] : dflt_lat;
    endfunction

    function automatic int mlat(input int i);
        return (i < mul_lq.size()) ? mul_lq[i] : dflt_lat;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Unit models: done becomes visible L cycles after the cycle start was high.
    always @(posedge clk) begin
        sq_done_m  <= 1'b0;
        mul_done_m <= 1'b0;
        if (reset) begin
            sq_cnt  <= 0;
            mul_cnt <= 0;
        end else begin
            if (sq_cnt != 0) begin
                sq_cnt <= sq_cnt - 1;
                if (sq_cnt == 1) sq_done_m <= 1'b1;
            end
            if (mul_cnt != 0) begin
                mul_cnt <= mul_cnt - 1;
                if (mul_cnt == 1) mul_done_m <= 1'b1;
            end
            if (sq_start) begin
                lat_s = slat(sq_pos);
                sq_pos++;
                if (lat_s <= 1) sq_done_m <= 1'b1;
                else sq_cnt <= lat_s - 1;
            end
            if (mul_start) begin
                lat_m = mlat(mul_pos);
                mul_pos++;
                if (lat_m <= 1) mul_done_m <= 1'b1;
                else mul_cnt <= lat_m - 1;
            end
        end
    end

    // Monitor: every pulse/enable cycle must match the next expected event.
    logic [10:0] obs;
    ev_t         e_pop;
    always @(negedge clk) begin
        if (!reset) begin
            if (sq_start)  n_sq++;
            if (mul_start) n_mul++;
            if (done | sq_start | mul_start | r0_load_rn | r0_we | r1_we) begin
                obs = {done, sq_start, mul_start, sq_sel, mul_sel, r0_load_rn, r0_we, r0_src, r1_we, r1_src};
                if (sb_q.size() == 0) begin
                    check("unexpected_event", 32'(obs), 32'd0);
                end else begin
                    e_pop = sb_q.pop_front();
                    check("ev_code", 32'(obs), 32'(e_pop.code));
                    check("ev_cycle", cyc - acc, e_pop.stamp);
                end
            end
            if (done) op_done = 1'b1;
        end
    end

    function automatic int clamp_len(input logic [5:0] l);
        return (l > 6'd32) ? 32 : int'(l);
    endfunction

    task automatic start_op(input logic [31:0] e, input logic [5:0] l);
        int n, t, si, mi, w, b;
        n = clamp_len(l);
        sb_q.delete();
        sb_q.push_back('{enc(0,0,1,0,2'd0,1,0,0,0,0), 0});
        t = mlat(0);
        sb_q.push_back('{enc(0,0,0,0,2'd0,0,0,0,1,0), t});
        t = t + 1;
        si = 0;
        mi = 1;
        for (int i = n - 1; i >= 0; i--) begin
            b = int'(e[i]);
            sb_q.push_back('{enc(0,1,1,b[0],2'd1,0,0,0,0,0), t});
            w = (slat(si) > mlat(mi)) ? slat(si) : mlat(mi);
            si++;
            mi++;
            sb_q.push_back('{enc(0,0,0,b[0],2'd1,0,1,~b[0],1,b[0]), t + w + 1});
            t = t + w + 2;
        end
        sb_q.push_back('{enc(0,0,1,0,2'd2,0,0,0,0,0), t});
        t = t + mlat(mi);
        sb_q.push_back('{enc(0,0,0,0,2'd2,0,1,0,0,0), t});
        sb_q.push_back('{enc(1,0,0,0,2'd0,0,0,0,0,0), t + 1});
        n_sq = 0;
        n_mul = 0;
        op_done = 1'b0;
        sq_pos = 0;
        mul_pos = 0;
        @(negedge clk);
        exponent = e;
        exp_len = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        start = 1'b0;
        check("busy_run", 32'(busy), 32'd1);
    endtask

    task automatic run_op(input logic [31:0] e, input logic [5:0] l);
        int n;
        n = clamp_len(l);
        start_op(e, l);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (op_done) break;
            if (inject) begin
                // Spurious mul_done during write-back, start re-asserted in STEP_S.
                mul_spur = r0_we & r1_we;
                start = sq_start;
            end
        end
        mul_spur = 1'b0;
        start = 1'b0;
        check("done_seen", 32'(op_done), 32'd1);
        check("mul_starts", n_mul, n + 2);
        check("sq_starts", n_sq, n);
        check("sb_left", sb_q.size(), 0);
        @(negedge clk);
        #1;
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    function automatic logic [11:0] outs();
        return {busy, done, sq_start, mul_start, sq_sel, mul_sel, r0_load_rn, r0_we, r0_src, r1_we, r1_src};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_outs_held", 32'(outs()), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_outs", 32'(outs()), 32'd0);

        // Zero-length exponent: only the two conversion multiplies.
        dflt_lat = 3;
        run_op(32'h1234, 6'd0);

        // 0xB, four bits, equal latencies (dones coincide).
        dflt_lat = 2;
        run_op(32'hB, 6'd4);

        // Unequal latencies, swapped between steps.
        mul_lq = '{2, 2, 5, 2, 2};
        sq_lq  = '{5, 2, 5};
        run_op(32'h5, 6'd3);
        mul_lq.delete();
        sq_lq.delete();

        // Minimum latency, same-cycle dones.
        dflt_lat = 1;
        run_op(32'h2, 6'd2);

        // Start while busy and spurious mul_done in write-back.
        dflt_lat = 2;
        inject = 1'b1;
        run_op(32'h6, 6'd3);
        inject = 1'b0;

        // Length above EXP_W clamps to EXP_W.
        dflt_lat = 1;
        run_op($urandom, 6'd40);

        // Reset during STEP_W of the second step aborts immediately.
        dflt_lat = 3;
        start_op(32'h9, 6'd4);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (n_sq == 2) break;
        end
        check("reached_step2", n_sq, 2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_outs", 32'(outs()), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        sb_q.delete();
        @(negedge clk);
        #1;
        check("abort_no_done", 32'(op_done), 32'd0);
        reset = 1'b0;
        run_op(32'h9, 6'd4);
        run_op($urandom, 6'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
